uart_xmt_unit: RTL and testbench

Serial transmitter that converts a parallel word into an asynchronous UART frame: start bit, data bits LSB first, optional parity bit, and one or two stop bits. It is the transmit-side counterpart of the UART receive path in the same UART subsystem. It uses the same bit ordering and a configurable clocks-per-bit rate, so a looped-back `serial_out` is recovered intact by the receiver. Parallel data arrives through a valid/ready handshake from the host-side logic.

---
 rtl/uart_xmt_unit.sv | 126 ++++++++++++
 tb/tb_uart_xmt_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_xmt_unit.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits. Line falls one edge after
// handshake, frame is N*CLKS_PER_BIT cycles; xmt_ready is low for the whole frame, valid while busy is dropped.
module uart_xmt_unit #(
   parameter int WORD_SIZE    = 8,
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] xmt_data,
   input  logic                 xmt_valid,
   output logic                 xmt_ready,
   output logic                 serial_out,
   output logic                 xmt_busy,
   output logic                 xmt_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(WORD_SIZE + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(WORD_SIZE - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [WORD_SIZE-1:0] shreg;
   logic                 par_bit;
   logic                 bit_end;
   logic                 accept;
   logic                 line_nx;

   assign bit_end   = (clk_cnt == CNT_LAST);
   assign xmt_ready = (state == IDLE);
   assign xmt_busy  = (state != IDLE);
   assign accept    = xmt_valid && xmt_ready;

   // line_nx is the value for the next cycle, so each bit is loaded at the edge that starts it
   always_comb begin
      state_nx = state;
      line_nx  = 1'b1;
      xmt_done = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = START;
               line_nx  = 1'b0;
            end
         end
         START: begin
            line_nx = 1'b0;
            if (bit_end) begin
               state_nx = DATA;
               line_nx  = shreg[0];
            end
         end
         DATA: begin
            line_nx = shreg[0];
            if (bit_end) begin
               if (bit_cnt == DATA_LAST) begin
                  if (PARITY != 0) begin
                     state_nx = PAR;
                     line_nx  = par_bit;
                  end else begin
                     state_nx = STOP;
                     line_nx  = 1'b1;
                  end
               end else begin
                  line_nx = shreg[1];
               end
            end
         end
         PAR: begin
            line_nx = par_bit;
            if (bit_end) begin
               state_nx = STOP;
               line_nx  = 1'b1;
            end
         end
         STOP: begin
            line_nx = 1'b1;
            if (bit_end && (bit_cnt == STOP_LAST)) begin
               state_nx = IDLE;
               xmt_done = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         serial_out <= 1'b1;
      end else begin
         state      <= state_nx;
         serial_out <= line_nx;
         if (accept) begin
            shreg   <= xmt_data;
            par_bit <= (^xmt_data) ^ ODD_PAR;
            clk_cnt <= '0;
            bit_cnt <= '0;
         end else if (state != IDLE) begin
            clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
            if (bit_end) begin
               // bit_cnt is cleared leaving DATA so it can count stop bits
               if (state == DATA) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
               end else if (state == STOP) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_xmt_unit.sv
// Bench for uart_xmt_unit: four parameter variants, per-cycle frame checks from a vector table,
// and a serial receiver model on the default instance fed from a scoreboard queue.
module tb_uart_xmt_unit;

   localparam int C = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] xmt_data = 8'h00;
   logic [3:0] valid = 4'b0000;
   logic [3:0] rdy_w, so_w, busy_w, done_w;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_xmt_unit u0 (.clk(clk), .rst(rst), .xmt_data(xmt_data), .xmt_valid(valid[0]),
                     .xmt_ready(rdy_w[0]), .serial_out(so_w[0]), .xmt_busy(busy_w[0]), .xmt_done(done_w[0]));
   uart_xmt_unit #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .xmt_data(xmt_data), .xmt_valid(valid[1]),
                     .xmt_ready(rdy_w[1]), .serial_out(so_w[1]), .xmt_busy(busy_w[1]), .xmt_done(done_w[1]));
   uart_xmt_unit #(.PARITY(2)) u2 (.clk(clk), .rst(rst), .xmt_data(xmt_data), .xmt_valid(valid[2]),
                     .xmt_ready(rdy_w[2]), .serial_out(so_w[2]), .xmt_busy(busy_w[2]), .xmt_done(done_w[2]));
   uart_xmt_unit #(.STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .xmt_data(xmt_data), .xmt_valid(valid[3]),
                     .xmt_ready(rdy_w[3]), .serial_out(so_w[3]), .xmt_busy(busy_w[3]), .xmt_done(done_w[3]));

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   typedef struct {
      int          sel;
      logic [7:0]  data;
      int          nbits;
      logic [15:0] frame;   // bit k = line level during serial bit k (k=0 is start)
   } vec_t;

   // Drives one handshake, then checks every cycle of the frame against the expected bit pattern
   task automatic send_frame(input int sel, input logic [7:0] d, input int nbits, input logic [15:0] frame);
      int errs;
      int done_at;
      int done_cnt;
      @(negedge clk);
      check($sformatf("ready before send u%0d", sel), int'(rdy_w[sel]), 1);
      xmt_data   = d;
      valid[sel] = 1'b1;
      if (sel == 0) exp_q.push_back(d);
      @(negedge clk);
      valid[sel] = 1'b0;
      xmt_data   = ~d;
      check($sformatf("busy after accept u%0d", sel), int'(busy_w[sel]), 1);
      check($sformatf("ready low after accept u%0d", sel), int'(rdy_w[sel]), 0);
      done_at  = -1;
      done_cnt = 0;
      for (int k = 0; k < nbits; k++) begin
         errs = 0;
         for (int c = 0; c < C; c++) begin
            if (k > 0 || c > 0) @(negedge clk);
            if (so_w[sel] !== frame[k]) errs++;
            if (done_w[sel] === 1'b1) begin
               done_at = k * C + c + 1;
               done_cnt++;
            end
         end
         check($sformatf("u%0d data %h bit %0d (want %0d) bad cycles", sel, d, k, frame[k]), errs, 0);
      end
      check($sformatf("u%0d done cycle", sel), done_at, nbits * C);
      check($sformatf("u%0d done pulse count", sel), done_cnt, 1);
      @(negedge clk);
      check($sformatf("u%0d ready after frame", sel), int'(rdy_w[sel]), 1);
      check($sformatf("u%0d busy after frame", sel), int'(busy_w[sel]), 0);
      check($sformatf("u%0d line idle", sel), int'(so_w[sel]), 1);
   endtask

   // Receiver model for u0: samples mid-bit and pops the scoreboard
   initial begin
      logic [7:0] w;
      forever begin
         @(negedge clk);
         if (!rst && so_w[0] === 1'b0) begin
            repeat (C / 2) @(negedge clk);
            check("rx start mid-bit", int'(so_w[0]), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               w[i] = so_w[0];
            end
            repeat (C) @(negedge clk);
            check("rx stop bit", int'(so_w[0]), 1);
            check("rx frame expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx word", int'(w), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      vec_t tbl[10];
      int   j;
      int   seen;
      tbl[0] = '{0, 8'hA5, 10, {6'b0, 1'b1, 8'hA5, 1'b0}};
      tbl[1] = '{1, 8'hA5, 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
      tbl[2] = '{2, 8'hA5, 11, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}};
      tbl[3] = '{2, 8'h07, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
      tbl[4] = '{1, 8'h07, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
      tbl[5] = '{3, 8'h00, 11, {5'b0, 2'b11, 8'h00, 1'b0}};
      tbl[6] = '{0, 8'h00, 10, {6'b0, 1'b1, 8'h00, 1'b0}};
      tbl[7] = '{0, 8'hFF, 10, {6'b0, 1'b1, 8'hFF, 1'b0}};
      tbl[8] = '{0, 8'h5A, 10, {6'b0, 1'b1, 8'h5A, 1'b0}};
      tbl[9] = '{0, 8'h81, 10, {6'b0, 1'b1, 8'h81, 1'b0}};

      // reset, with a valid request that must be ignored
      repeat (3) @(negedge clk);
      valid[0] = 1'b1;
      xmt_data = 8'h3C;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset ready u%0d", i), int'(rdy_w[i]), 1);
         check($sformatf("reset busy u%0d", i), int'(busy_w[i]), 0);
         check($sformatf("reset line u%0d", i), int'(so_w[i]), 1);
         check($sformatf("reset done u%0d", i), int'(done_w[i]), 0);
      end
      rst      = 1'b0;
      valid[0] = 1'b0;
      @(negedge clk);
      check("valid during reset not taken", int'(rdy_w[0]), 1);

      for (int v = 0; v < 10; v++) send_frame(tbl[v].sel, tbl[v].data, tbl[v].nbits, tbl[v].frame);

      // back-to-back with valid held; data changed mid-frame must not matter
      @(negedge clk);
      xmt_data = 8'h55;
      valid[0] = 1'b1;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      @(negedge clk);
      xmt_data = 8'hAA;
      j = 1;
      while (done_w[0] !== 1'b1 && j < 200) begin
         @(negedge clk);
         j++;
      end
      check("b2b first done cycle", j, 10 * C);
      @(negedge clk);
      check("b2b gap line high", int'(so_w[0]), 1);
      check("b2b gap ready", int'(rdy_w[0]), 1);
      @(negedge clk);
      check("b2b second start low", int'(so_w[0]), 0);
      check("b2b second busy", int'(busy_w[0]), 1);
      valid[0] = 1'b0;
      j = 1;
      repeat (20) begin
         @(negedge clk);
         j++;
      end
      xmt_data = 8'hFF;
      valid[0] = 1'b1;
      @(negedge clk);
      j++;
      valid[0] = 1'b0;
      while (done_w[0] !== 1'b1 && j < 200) begin
         @(negedge clk);
         j++;
      end
      check("b2b second done cycle", j, 10 * C);
      repeat (2) @(negedge clk);
      check("no frame from busy pulse", int'(so_w[0]), 1);
      check("idle after b2b", int'(rdy_w[0]), 1);

      // reset during data bit 3 of u1
      @(negedge clk);
      xmt_data = 8'hB6;
      valid[1] = 1'b1;
      @(negedge clk);
      valid[1] = 1'b0;
      repeat (35) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid reset line", int'(so_w[1]), 1);
      check("mid reset ready", int'(rdy_w[1]), 1);
      check("mid reset busy", int'(busy_w[1]), 0);
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (done_w[1] === 1'b1 || so_w[1] !== 1'b1) seen++;
      end
      check("no activity after abort", seen, 0);
      send_frame(1, 8'h3C, 11, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0});

      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
